// File: rtl/cmp_pkg.sv
// Shared types and constants for the multi-cycle comparator.
// FSM states, compare codes, RV32 branch funct3 values and the taken decode.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;
  localparam logic [1:0] RES_GT = 2'b00;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic taken_of(
    input logic [2:0] f3,
    input logic [1:0] r
  );
    logic eq;
    logic lt;
    logic t;
    eq = (r == RES_EQ);
    lt = (r == RES_LT);
    t  = 1'b0;
    case (f3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = lt;
      F3_BGE:  t = !lt;
      F3_BLTU: t = lt;
      F3_BGEU: t = !lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle MSB-first comparator with RV32 branch-taken decode.
// CMP_SEQ_EARLY_EXIT_EN: stop scanning at the first differing chunk.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             signed_en,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       res,
  output logic             taken
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef CMP_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f3_q;
  logic [IW-1:0]    idx;
  logic             found;
  logic             lt_q;

  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic             c_eq;
  logic             c_lt;
  logic             found_n;
  logic             lt_n;
  logic             stop;
  logic [1:0]       res_n;

  assign sa = a_q[idx*CHUNK +: CHUNK];
  assign sb = b_q[idx*CHUNK +: CHUNK];

  cmp_chunk #(
    .W(CHUNK)
  ) u_chunk (
    .a (sa),
    .b (sb),
    .eq(c_eq),
    .lt(c_lt)
  );

  // Only the most significant differing chunk decides the order.
  always_comb begin
    found_n = found | ~c_eq;
    lt_n    = found ? lt_q : c_lt;
    stop    = (idx == '0) | (EARLY & ~c_eq);
    res_n   = RES_EQ;
    if (found_n) res_n = lt_n ? RES_LT : RES_GT;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      idx       <= '0;
      found     <= 1'b0;
      lt_q      <= 1'b0;
      out_valid <= 1'b0;
      res       <= RES_GT;
      taken     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Flipping the sign bits maps signed order onto unsigned order.
            a_q   <= signed_en ? (input_a ^ MSB) : input_a;
            b_q   <= signed_en ? (input_b ^ MSB) : input_b;
            f3_q  <= funct3;
            idx   <= LAST;
            found <= 1'b0;
            lt_q  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          found <= found_n;
          lt_q  <= lt_n;
          if (stop) begin
            res       <= res_n;
            taken     <= taken_of(f3_q, res_n);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
// Directed, table-driven bench for cmp_seq (WIDTH=32, CHUNK=8).
module tb_cmp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        signed_en;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  res;
  logic        taken;

  int n_run = 0;
  int n_fail = 0;
  int deliveries = 0;

  always #5 clk = ~clk;

  cmp_seq #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .input_a  (input_a),
    .input_b  (input_b),
    .signed_en(signed_en),
    .funct3   (funct3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .taken    (taken)
  );

  always @(posedge clk) if (!rst && out_valid && out_ready) deliveries++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [2:0]  f3;
    logic [1:0]  r;
    logic        t;
    int          c_early;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat(input int c_early);
`ifdef CMP_SEQ_EARLY_EXIT_EN
    return c_early;
`else
    return 4 + 0 * c_early;
`endif
  endfunction

  // Issue one op and wait for its result; c = cycles from accept edge.
  task automatic start(input vec_t v);
    @(negedge clk);
    chk("in_ready_before", int'(in_ready), 1);
    in_valid  = 1'b1;
    input_a   = v.a;
    input_b   = v.b;
    signed_en = v.s;
    funct3    = v.f3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!out_valid) begin
      n_run++;
      n_fail++;
      $display("FAIL timeout: out_valid never rose after %0d cycles", c);
    end
  endtask

  initial begin
    int c;
    int d0;
    logic [1:0] r0;
    logic t0;

    vecs[0]  = '{32'h5, 32'h7, 1'b0, 3'b110, 2'b10, 1'b1, 4};
    vecs[1]  = '{32'hFFFFFFFF, 32'h1, 1'b1, 3'b100, 2'b10, 1'b1, 1};
    vecs[2]  = '{32'hFFFFFFFF, 32'h1, 1'b0, 3'b100, 2'b00, 1'b0, 1};
    vecs[3]  = '{32'h12345678, 32'h12345678, 1'b0, 3'b000, 2'b01, 1'b1, 4};
    vecs[4]  = '{32'h80000000, 32'h0, 1'b0, 3'b001, 2'b00, 1'b1, 1};
    vecs[5]  = '{32'h80000000, 32'h0, 1'b1, 3'b101, 2'b10, 1'b0, 1};
    vecs[6]  = '{32'h00010000, 32'h00020000, 1'b0, 3'b111, 2'b10, 1'b0, 2};
    vecs[7]  = '{32'h00000100, 32'h000000FF, 1'b0, 3'b010, 2'b00, 1'b0, 3};
    vecs[8]  = '{32'h0, 32'h0, 1'b0, 3'b001, 2'b01, 1'b0, 4};
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b1, 3'b101, 2'b01, 1'b1, 4};
    vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b100, 2'b00, 1'b0, 1};
    vecs[11] = '{32'h1, 32'h2, 1'b0, 3'b011, 2'b10, 1'b0, 4};
    vecs[12] = '{32'h2, 32'h1, 1'b1, 3'b110, 2'b00, 1'b0, 4};

    rst       = 1'b1;
    in_valid  = 1'b0;
    input_a   = '0;
    input_b   = '0;
    signed_en = 1'b0;
    funct3    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_res", int'(res), 0);
    chk("rst_taken", int'(taken), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 13; i++) begin
      start(vecs[i]);
      wait_out(c);
      chk($sformatf("v%0d_res", i), int'(res), int'(vecs[i].r));
      chk($sformatf("v%0d_taken", i), int'(taken), int'(vecs[i].t));
      chk($sformatf("v%0d_lat", i), c, lat(vecs[i].c_early));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle", i), int'(in_ready), 1);
    end

    // Backpressure: result held while new commands are offered.
    out_ready = 1'b0;
    d0 = deliveries;
    start(vecs[0]);
    wait_out(c);
    r0 = res;
    t0 = taken;
    chk("bp_res", int'(r0), 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = k[0];
      input_a   = $urandom;
      input_b   = $urandom;
      signed_en = k[1];
      @(posedge clk);
      #1;
      chk("bp_hold_res", int'(res), int'(r0));
      chk("bp_hold_taken", int'(taken), int'(t0));
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop_valid", int'(out_valid), 0);
    chk("bp_ready_again", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_one_result", deliveries - d0, 1);

    // Reset while RUN is at idx=2.
    d0 = deliveries;
    start('{32'h1, 32'h0, 1'b0, 3'b001, 2'b00, 1'b1, 4});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_res", int'(res), 0);
    chk("mr_taken", int'(taken), 0);
    chk("mr_in_ready", int'(in_ready), 1);
    start(vecs[3]);
    wait_out(c);
    chk("mr_new_res", int'(res), 1);
    chk("mr_new_taken", int'(taken), 1);
    chk("mr_new_lat", c, 4);
    @(posedge clk);
    #1;
    chk("mr_deliveries", deliveries - d0, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_seq.md
# cmp_seq

Multi-cycle, parametrised successor of the single-cycle comparator in the RV32 datapath. It compares two WIDTH-bit operands CHUNK bits per cycle, MSB-first, in signed or unsigned mode, and returns the standard 2-bit compare code. It also returns a branch-taken flag decoded from an RV32 branch funct3. It sits between the decode/issue stage and branch resolution, behind valid/ready handshakes on both sides, so wide operands do not lengthen the critical path.

## Interface
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle, ≥1. NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands/command valid.
- in_ready  out  1  block can accept; equals (state==IDLE).
- input_a  in  WIDTH  operand A.
- input_b  in  WIDTH  operand B.
- signed_en  in  1  1 = two's-complement compare, 0 = unsigned.
- funct3  in  3  branch condition used for `taken`.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res  out  2  01 = equal, 10 = A<B, 00 = A>B; 11 is never produced.
- taken  out  1  branch condition result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid, capture the operands, funct3 and signed_en.
  - If signed_en=1, invert bit WIDTH-1 of both captured operands. After this, an unsigned compare gives the signed order.
  - Set idx=NCHUNK-1, clear `found`, go to RUN.
- RUN (one chunk per cycle, slice [idx*CHUNK +: CHUNK])
  - If the slices differ and `found`=0: latch lt = (a_slice < b_slice) and set `found`.
  - Exit condition:
    - With early exit, leave RUN on the first difference.
    - In all cases, leave RUN when idx==0.
    - On exit, res = 01 if nothing was found, else (lt ? 10 : 00). Go to DONE.
  - Otherwise decrement idx.
- DONE
  - out_valid=1; res and taken are held stable.
  - On out_ready, go to IDLE.
- Taken decode from the latched res:
  - 000: eq.
  - 001: !eq.
  - 100 and 110: lt.
  - 101 and 111: !lt.
  - 010 and 011: 0.
  - Signedness comes only from signed_en; funct3 does not override it.
- in_ready=0 in RUN and DONE; in_valid is ignored there. There is no overlap of operations.
- res and taken are registered and change only on the RUN→DONE edge.

## Timing
- Reset values: state=IDLE, out_valid=0, res=00, taken=0, idx=0, found=0. in_ready=1 from the first cycle after reset.
- Acceptance edge t0: handshake in_valid&in_ready.
- out_valid is first high in the cycle after edge t0+c, where c is the number of chunks examined:
  - with early exit, c is 1..NCHUNK;
  - without early exit, c is always NCHUNK.
- The result handshake completes on the edge where out_valid&out_ready. in_ready is high in the next cycle, so the minimum initiation interval is c+2.
- rst during RUN or DONE: at the next edge, the FSM returns to IDLE with all outputs at reset values. No result is emitted.
- rst has priority over every handshake in the same cycle.
- NCHUNK=1 is legal: always c=1.

## Configuration
- Macro CMP_SEQ_EARLY_EXIT_EN.
  - Defined: RUN terminates on the first differing chunk. Latency depends on the data.
  - Undefined: all NCHUNK chunks are always scanned. Latency is fixed and data-independent, which is timing-side-channel safe. Results are identical in both builds.

## Structure
- Shared package cmp_pkg holds:
  - the FSM state enum;
  - result constants RES_EQ=2'b01, RES_LT=2'b10, RES_GT=2'b00;
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
- Sub-module cmp_chunk: a combinational CHUNK-bit unsigned compare producing eq and lt, instantiated once.

## Test plan
- Unsigned less-than, default params, early exit on: input_a=5, input_b=7, signed_en=0, funct3=110 → res=10, taken=1, c=4.
- Signed vs unsigned ordering: input_a=0xFFFFFFFF, input_b=1.
  - signed_en=1, funct3=100 → res=10, taken=1.
  - signed_en=0 → res=00.
- Equal operands: 0x12345678 vs 0x12345678, funct3=000 → res=01, taken=1. out_valid appears after c=4 in both builds.
- Early-exit latency: input_a=0x80000000, input_b=0, signed_en=0 → res=00.
  - Macro defined: out_valid after c=1.
  - Macro undefined: out_valid after c=4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands → res and taken remain stable, in_ready=0, and only one result is delivered.
- Reset mid-RUN: assert rst at idx=2 → next cycle out_valid=0, res=00, taken=0, in_ready=1. A new compare afterwards completes correctly.
